// File: rtl/rd_req_tlp_sender_pkg.sv
// rtl/rd_req_tlp_sender_pkg.sv - shared constants, FSM states and DW0 helper for the read-request TLP sender
package rd_req_tlp_sender_pkg;

    localparam logic [6:0] MRD64_FMT_TYPE = 7'b01_00000;
    localparam logic [6:0] MRD32_FMT_TYPE = 7'b00_00000;
    localparam logic [9:0] CHUNK_LEN_DW   = 10'd128;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_BEAT0 = 4'b0010,
        ST_BEAT1 = 4'b0100,
        ST_GAP   = 4'b1000
    } state_e;

    // R | fmt/type | R | TC | R | TD | EP | Attr | R | Length
    function automatic logic [31:0] hdr_dw0(input logic [6:0] fmt_type);
        return {1'b0, fmt_type, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, CHUNK_LEN_DW};
    endfunction

endpackage

// File: rtl/rd_req_tlp_sender_hdr_build.sv
// rtl/rd_req_tlp_sender_hdr_build.sv - combinational MRd header DW0..DW3; MRD32_OPT_EN selects 3DW for 32-bit addresses
module rd_req_hdr_build
    import rd_req_tlp_sender_pkg::*;
(
    input  logic [63:0] addr_i,
    input  logic [7:0]  tag_i,
    input  logic [15:0] id_i,
    output logic [31:0] dw0_o,
    output logic [31:0] dw1_o,
    output logic [31:0] dw2_o,
    output logic [31:0] dw3_o,
    output logic        is_3dw_o
);

    always_comb begin
`ifdef MRD32_OPT_EN
        is_3dw_o = (addr_i[63:32] == 32'h0);
`else
        is_3dw_o = 1'b0;
`endif
        dw0_o = hdr_dw0(is_3dw_o ? MRD32_FMT_TYPE : MRD64_FMT_TYPE);
        dw1_o = {id_i, tag_i, 4'hF, 4'hF};
        if (is_3dw_o) begin
            dw2_o = {addr_i[31:2], 2'b00};
            dw3_o = 32'h0;
        end else begin
            dw2_o = addr_i[63:32];
            dw3_o = {addr_i[31:2], 2'b00};
        end
    end

endmodule

// File: rtl/rd_req_tlp_sender.sv
// rtl/rd_req_tlp_sender.sv - issues one 512-byte MRd TLP per read_chunk request on the TRN TX interface (option MRD32_OPT_EN)
module rd_req_tlp_sender
    import rd_req_tlp_sender_pkg::*;
(
    input  logic        trn_clk,
    input  logic        reset_n,
    input  logic        read_chunk,
    input  logic [63:0] huge_page_addr_read_from,
    output logic        read_chunk_ack,
    input  logic [15:0] cfg_completer_id,
    input  logic [5:0]  trn_tbuf_av,
    input  logic        trn_tdst_rdy_n,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    output logic        trn_tsrc_dsc_n,
    output logic [31:0] rd_req_count
);

    state_e      state_q, state_d;
    logic [63:0] addr_q;
    logic [7:0]  tag_q;
    logic [31:0] count_q;
    logic        ack_q, ack_d;
    logic        load_addr;

    logic [31:0] dw0, dw1, dw2, dw3;
    logic        is_3dw;

    // only the non-posted credit bit gates new requests
    logic unused_tbuf_bits;
    assign unused_tbuf_bits = ^{trn_tbuf_av[5:2], trn_tbuf_av[0]};

    rd_req_hdr_build u_hdr (
        .addr_i   (addr_q),
        .tag_i    (tag_q),
        .id_i     (cfg_completer_id),
        .dw0_o    (dw0),
        .dw1_o    (dw1),
        .dw2_o    (dw2),
        .dw3_o    (dw3),
        .is_3dw_o (is_3dw)
    );

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 64'h0;
            tag_q   <= 8'h0;
            count_q <= 32'h0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            if (load_addr) begin
                addr_q <= huge_page_addr_read_from;
            end
            if (ack_d) begin
                tag_q   <= tag_q + 8'd1;
                count_q <= count_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        load_addr      = 1'b0;
        ack_d          = 1'b0;
        trn_tsrc_rdy_n = 1'b1;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_td         = 64'h0;
        trn_trem_n     = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (read_chunk && trn_tbuf_av[1]) begin
                    state_d   = ST_BEAT0;
                    load_addr = 1'b1;
                end
            end
            ST_BEAT0: begin
                trn_tsrc_rdy_n = 1'b0;
                trn_tsof_n     = 1'b0;
                trn_td         = {dw0, dw1};
                if (!trn_tdst_rdy_n) begin
                    state_d = ST_BEAT1;
                end
            end
            ST_BEAT1: begin
                trn_tsrc_rdy_n = 1'b0;
                trn_teof_n     = 1'b0;
                trn_td         = {dw2, dw3};
                trn_trem_n     = is_3dw ? 8'h0F : 8'h00;
                if (!trn_tdst_rdy_n) begin
                    state_d = ST_GAP;
                    ack_d   = 1'b1;
                end
            end
            ST_GAP: begin
                // one idle cycle lets the requester drop read_chunk after the ack
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign read_chunk_ack = ack_q;
    assign rd_req_count   = count_q;
    assign trn_tsrc_dsc_n = 1'b1;

endmodule

// File: tb/tb_rd_req_tlp_sender.sv
// tb/tb_rd_req_tlp_sender.sv - randomized self-checking bench for rd_req_tlp_sender with a request-level reference model
module tb_rd_req_tlp_sender;

    logic        trn_clk = 1'b0;
    logic        reset_n;
    logic        read_chunk;
    logic [63:0] huge_page_addr_read_from;
    logic        read_chunk_ack;
    logic [15:0] cfg_completer_id;
    logic [5:0]  trn_tbuf_av;
    logic        trn_tdst_rdy_n;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tsrc_dsc_n;
    logic [31:0] rd_req_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  m_tag;
    logic [31:0] m_count;

    rd_req_tlp_sender dut (
        .trn_clk                  (trn_clk),
        .reset_n                  (reset_n),
        .read_chunk               (read_chunk),
        .huge_page_addr_read_from (huge_page_addr_read_from),
        .read_chunk_ack           (read_chunk_ack),
        .cfg_completer_id         (cfg_completer_id),
        .trn_tbuf_av              (trn_tbuf_av),
        .trn_tdst_rdy_n           (trn_tdst_rdy_n),
        .trn_td                   (trn_td),
        .trn_trem_n               (trn_trem_n),
        .trn_tsof_n               (trn_tsof_n),
        .trn_teof_n               (trn_teof_n),
        .trn_tsrc_rdy_n           (trn_tsrc_rdy_n),
        .trn_tsrc_dsc_n           (trn_tsrc_dsc_n),
        .rd_req_count             (rd_req_count)
    );

    always #2 trn_clk = ~trn_clk;
    always @(posedge trn_clk) cyc = cyc + 1;

    function automatic bit model_is3(input logic [63:0] a);
        bit opt = 1'b0;
`ifdef MRD32_OPT_EN
        opt = 1'b1;
`endif
        return opt && ((a >> 32) == 64'h0);
    endfunction

    function automatic logic [63:0] model_beat0(input logic [63:0] a, input logic [15:0] id, input logic [7:0] tag);
        logic [63:0] fmt;
        fmt = model_is3(a) ? 64'h00 : 64'h20;
        return (fmt << 56) | (64'd128 << 32) | ({48'h0, id} << 16) | ({56'h0, tag} << 8) | 64'hFF;
    endfunction

    function automatic logic [63:0] model_beat1(input logic [63:0] a);
        if (model_is3(a)) return (a & 64'hFFFF_FFFC) << 32;
        return a & ~64'h3;
    endfunction

    function automatic logic [7:0] model_trem(input logic [63:0] a);
        return model_is3(a) ? 8'h0F : 8'h00;
    endfunction

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        a = {$urandom, $urandom};
        if ($urandom_range(0, 2) == 0) a = a & 64'h0000_0000_FFFF_FFFF;
        return a;
    endfunction

    task automatic apply_reset();
        @(negedge trn_clk);
        reset_n        = 1'b0;
        read_chunk     = 1'b0;
        trn_tdst_rdy_n = 1'b1;
        repeat (2) @(negedge trn_clk);
        reset_n = 1'b1;
        m_tag   = 8'h00;
        m_count = 32'h0;
    endtask

    // Requester + sink driver: returns what it observed, judges nothing.
    task automatic do_req(input logic [63:0] a, input logic [15:0] id, input int st0, input int st1,
                          output logic [63:0] b0, output logic [63:0] b1, output logic [7:0] r1,
                          output int lat, output bit unstable, output bit timeout);
        bit seen0 = 1'b0;
        bit seen1 = 1'b0;
        int c_b1  = 0;
        int s0    = st0;
        int s1    = st1;
        b0 = '0; b1 = '0; r1 = '0; lat = -1; unstable = 1'b0; timeout = 1'b1;
        huge_page_addr_read_from = a;
        cfg_completer_id         = id;
        read_chunk               = 1'b1;
        trn_tdst_rdy_n           = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge trn_clk);
            if (!trn_tsrc_rdy_n && !trn_tsof_n) begin
                if (!seen0) b0 = trn_td;
                else if (trn_td !== b0) unstable = 1'b1;
                seen0 = 1'b1;
                trn_tdst_rdy_n = (s0 > 0);
                s0--;
            end else if (!trn_tsrc_rdy_n && !trn_teof_n) begin
                if (!seen1) begin
                    b1 = trn_td;
                    r1 = trn_trem_n;
                end else if (trn_td !== b1 || trn_trem_n !== r1) unstable = 1'b1;
                seen1 = 1'b1;
                c_b1  = i;
                trn_tdst_rdy_n = (s1 > 0);
                s1--;
            end else begin
                trn_tdst_rdy_n = 1'b1;
            end
            if (read_chunk_ack === 1'b1) begin
                lat        = seen1 ? i - c_b1 : -1;
                read_chunk = 1'b0;
                timeout    = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n} !== 4'hF) begin
            errors++; $display("FAIL reset_ctl got %b want 1111", {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n});
        end
        checks++;
        if (trn_td !== 64'h0 || trn_trem_n !== 8'h00) begin
            errors++; $display("FAIL reset_data td=%h trem=%h want 0/00", trn_td, trn_trem_n);
        end
        checks++;
        if (read_chunk_ack !== 1'b0 || rd_req_count !== 32'h0) begin
            errors++; $display("FAIL reset_ack_cnt ack=%b cnt=%0d want 0/0", read_chunk_ack, rd_req_count);
        end
    endtask

    task automatic test_basic();
        logic [63:0] b0, b1; logic [7:0] r1; int lat; bit uns, to;
        do_req(64'h0000_0001_2345_6000, 16'h0100, 0, 0, b0, b1, r1, lat, uns, to);
        m_tag++; m_count++;
        checks++;
        if (to || b0 !== 64'h2000_0080_0100_00FF) begin
            errors++; $display("FAIL basic_beat0 got %h timeout=%0b want 2000008001000 0ff", b0, to);
        end
        checks++;
        if (b1 !== 64'h0000_0001_2345_6000 || r1 !== 8'h00) begin
            errors++; $display("FAIL basic_beat1 got %h trem=%h want 0000000123456000/00", b1, r1);
        end
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL basic_ack_lat got %0d want 1", lat);
        end
        @(negedge trn_clk);
        checks++;
        if (read_chunk_ack !== 1'b0 || rd_req_count !== 32'd1) begin
            errors++; $display("FAIL basic_after ack=%b cnt=%0d want 0/1", read_chunk_ack, rd_req_count);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b0, b1; logic [7:0] r1; logic [15:0] id; int lat; bit uns, to;
        a = rand_addr(); id = 16'($urandom);
        do_req(a, id, 5, 5, b0, b1, r1, lat, uns, to);
        checks++;
        if (to || b0 !== model_beat0(a, id, m_tag)) begin
            errors++; $display("FAIL bp_beat0 got %h want %h (tag 1 expected)", b0, model_beat0(a, id, m_tag));
        end
        checks++;
        if (b1 !== model_beat1(a) || r1 !== model_trem(a)) begin
            errors++; $display("FAIL bp_beat1 got %h/%h want %h/%h", b1, r1, model_beat1(a), model_trem(a));
        end
        checks++;
        if (uns) begin
            errors++; $display("FAIL bp_stable got unstable=1 want 0");
        end
        m_tag++; m_count++;
        @(negedge trn_clk);
        checks++;
        if (lat !== 1 || read_chunk_ack !== 1'b0) begin
            errors++; $display("FAIL bp_single_ack lat=%0d ack_after=%b want 1/0", lat, read_chunk_ack);
        end
    endtask

    task automatic test_no_credit();
        logic [63:0] a, b0, b1; logic [7:0] r1; logic [15:0] id; int lat, bad; bit uns, to;
        a = rand_addr(); id = 16'($urandom); bad = 0;
        huge_page_addr_read_from = a; cfg_completer_id = id;
        trn_tbuf_av = 6'b111101; read_chunk = 1'b1; trn_tdst_rdy_n = 1'b1;
        repeat (10) begin
            @(negedge trn_clk);
            if (trn_tsrc_rdy_n !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL nocredit_hold got %0d active cycles want 0", bad);
        end
        trn_tbuf_av = 6'b000010;
        @(negedge trn_clk);
        checks++;
        if (trn_tsrc_rdy_n !== 1'b0 || trn_tsof_n !== 1'b0) begin
            errors++; $display("FAIL nocredit_start src=%b sof=%b want 0/0", trn_tsrc_rdy_n, trn_tsof_n);
        end
        // credit dropping mid-packet must not stall the TLP
        trn_tbuf_av = 6'b000000;
        do_req(a, id, 1, 2, b0, b1, r1, lat, uns, to);
        trn_tbuf_av = 6'b000010;
        checks++;
        if (to || b0 !== model_beat0(a, id, m_tag) || b1 !== model_beat1(a)) begin
            errors++; $display("FAIL nocredit_tlp got %h %h timeout=%0b want %h %h", b0, b1, to, model_beat0(a, id, m_tag), model_beat1(a));
        end
        m_tag++; m_count++;
    endtask

    task automatic test_random();
        logic [63:0] a, b0, b1; logic [7:0] r1; logic [15:0] id; int lat; bit uns, to;
        for (int k = 0; k < 24; k++) begin
            a = rand_addr(); id = 16'($urandom);
            do_req(a, id, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), b0, b1, r1, lat, uns, to);
            checks++;
            if (to || uns || lat !== 1 || b0 !== model_beat0(a, id, m_tag) || b1 !== model_beat1(a) || r1 !== model_trem(a)) begin
                errors++;
                $display("FAIL rand_%0d got %h %h %h lat=%0d uns=%0b to=%0b want %h %h %h lat=1", k, b0, b1, r1, lat, uns, to,
                         model_beat0(a, id, m_tag), model_beat1(a), model_trem(a));
            end
            m_tag++; m_count++;
            checks++;
            if (rd_req_count !== m_count) begin
                errors++; $display("FAIL rand_cnt_%0d got %0d want %0d", k, rd_req_count, m_count);
            end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] a, b0, b1; logic [7:0] r1; logic [15:0] id; int lat, prev, short_cnt; bit uns, to;
        apply_reset();
        prev = -100; short_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            a = rand_addr(); id = 16'($urandom);
            do_req(a, id, 0, 0, b0, b1, r1, lat, uns, to);
            checks++;
            if (to || b0 !== model_beat0(a, id, m_tag) || b1 !== model_beat1(a)) begin
                errors++; $display("FAIL wrap_%0d got %h %h to=%0b want %h %h", k, b0, b1, to, model_beat0(a, id, m_tag), model_beat1(a));
            end
            if (cyc - prev < 4) short_cnt++;
            prev = cyc;
            m_tag++; m_count++;
        end
        checks++;
        if (short_cnt != 0) begin
            errors++; $display("FAIL wrap_spacing got %0d requests under 4 cycles want 0", short_cnt);
        end
        checks++;
        if (rd_req_count !== 32'd256) begin
            errors++; $display("FAIL wrap_count got %0d want 256", rd_req_count);
        end
        a = rand_addr(); id = 16'($urandom);
        do_req(a, id, 0, 0, b0, b1, r1, lat, uns, to);
        b0 = b0 >> 8;
        checks++;
        if (to || b0[7:0] !== 8'h00) begin
            errors++; $display("FAIL wrap_tag got %h want 00", b0[7:0]);
        end
        m_tag++; m_count++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] a, b0, b1; logic [7:0] r1; logic [15:0] id; int lat, bad; bit uns, to, hit;
        a = rand_addr(); id = 16'($urandom); hit = 1'b0; bad = 0;
        huge_page_addr_read_from = a; cfg_completer_id = id;
        read_chunk = 1'b1; trn_tdst_rdy_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge trn_clk);
            if (!trn_tsrc_rdy_n && !trn_tsof_n) trn_tdst_rdy_n = 1'b0;
            else if (!trn_tsrc_rdy_n && !trn_teof_n) begin
                trn_tdst_rdy_n = 1'b1;
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL rstmid_reach got no beat1 want beat1 within 20 cycles");
        end
        reset_n = 1'b0; read_chunk = 1'b0;
        @(negedge trn_clk);
        checks++;
        if ({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n, read_chunk_ack} !== 5'b11110 ||
            trn_td !== 64'h0 || trn_trem_n !== 8'h00 || rd_req_count !== 32'h0) begin
            errors++; $display("FAIL rstmid_outs ctl=%b td=%h trem=%h cnt=%0d want 11110/0/00/0",
                               {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n, read_chunk_ack}, trn_td, trn_trem_n, rd_req_count);
        end
        reset_n = 1'b1; trn_tdst_rdy_n = 1'b0;
        m_tag = 8'h00; m_count = 32'h0;
        repeat (6) begin
            @(negedge trn_clk);
            if (read_chunk_ack !== 1'b0 || trn_tsrc_rdy_n !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rstmid_noresume got %0d active cycles want 0", bad);
        end
        a = rand_addr(); id = 16'($urandom);
        do_req(a, id, 0, 0, b0, b1, r1, lat, uns, to);
        checks++;
        if (to || b0 !== model_beat0(a, id, m_tag) || rd_req_count !== 32'd1) begin
            errors++; $display("FAIL rstmid_next got %h cnt=%0d want %h cnt=1", b0, rd_req_count, model_beat0(a, id, m_tag));
        end
        m_tag++; m_count++;
    endtask

`ifdef MRD32_OPT_EN
    task automatic test_mrd32();
        logic [63:0] b0, b1; logic [7:0] r1; int lat; bit uns, to;
        apply_reset();
        do_req(64'h0000_0000_8000_0200, 16'h0100, 0, 0, b0, b1, r1, lat, uns, to);
        checks++;
        if (to || b0 !== 64'h0000_0080_0100_00FF) begin
            errors++; $display("FAIL mrd32_beat0 got %h want 00000080010000ff", b0);
        end
        checks++;
        if (b1 !== 64'h8000_0200_0000_0000 || r1 !== 8'h0F) begin
            errors++; $display("FAIL mrd32_beat1 got %h/%h want 8000020000000000/0f", b1, r1);
        end
        m_tag++; m_count++;
    endtask
`endif

    initial begin
        reset_n                  = 1'b0;
        read_chunk               = 1'b0;
        huge_page_addr_read_from = 64'h0;
        cfg_completer_id         = 16'h0;
        trn_tbuf_av              = 6'b000010;
        trn_tdst_rdy_n           = 1'b1;
        m_tag                    = 8'h00;
        m_count                  = 32'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_no_credit();
        test_random();
        test_wrap();
        test_reset_mid();
`ifdef MRD32_OPT_EN
        test_mrd32();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rd_req_tlp_sender.md
RD_REQ_TLP_SENDER -- requirements
Module: rd_req_tlp_sender

Interface
REQ-001 trn_clk  in  1  TRN user clock (250 MHz); all logic is synchronous to it.
REQ-002 reset_n  in  1  Reset: asynchronous, active-low.
REQ-003 read_chunk  in  1  Level request for one 512-byte read; held until read_chunk_ack.
REQ-004 huge_page_addr_read_from  in  64  Host byte address of the chunk; valid while read_chunk=1.
REQ-005 read_chunk_ack  out  1  One-cycle pulse: request TLP fully accepted by the core.
REQ-006 cfg_completer_id  in  16  Bus/dev/func, used as Requester ID.
REQ-007 trn_tbuf_av  in  6  Core TX buffer availability; bit 1 = non-posted credit.
REQ-008 trn_tdst_rdy_n  in  1  Core ready, active-low.
REQ-009 trn_td  out  64  TX data beat.
REQ-010 trn_trem_n  out  8  Remainder, active-low byte enables.
REQ-011 trn_tsof_n / trn_teof_n  out  1 each  Start/end of frame, active-low.
REQ-012 trn_tsrc_rdy_n  out  1  Source ready, active-low.
REQ-013 trn_tsrc_dsc_n  out  1  Discontinue; held at 1.
REQ-014 rd_req_count  out  32  Number of requests accepted since reset; wraps.

Function
REQ-015 FSM states: IDLE, BEAT0, BEAT1, GAP; one-hot encoding.
REQ-016 IDLE -> BEAT0 when read_chunk=1 and trn_tbuf_av[1]=1; capture the address and the current tag on that edge.
REQ-017 BEAT0 drives tsrc_rdy_n=0, tsof_n=0, teof_n=1, trem_n=8'h00, td={DW0,DW1}; the beat holds until trn_tdst_rdy_n=0, then goes to BEAT1.
REQ-018 DW0 fields: fmt/type=7'b01_00000 (MRd64), TC=0, TD=0, EP=0, Attr=0, Length=10'h080 (128 DW = 512 B).
REQ-019 DW1 fields: {cfg_completer_id, tag[7:0], LastBE=4'hF, FirstBE=4'hF}.
REQ-020 BEAT1 drives tsof_n=1, teof_n=0, trem_n=8'h00, td={addr[63:32], addr[31:2], 2'b00}; the beat holds until trn_tdst_rdy_n=0.
REQ-021 On BEAT1 acceptance: read_chunk_ack=1 for exactly the next cycle; tag and rd_req_count increment by 1 (mod 2^8 and 2^32); FSM -> GAP.
REQ-022 GAP lasts one cycle with tsrc_rdy_n=1, then FSM -> IDLE; the requester's read_chunk deassert is seen before a new request is sampled.
REQ-023 Outside BEAT0/BEAT1: tsrc_rdy_n=1, tsof_n=1, teof_n=1, td=0.
REQ-024 tdst_rdy_n=1 mid-packet: current beat and all outputs frozen; no timeout.
REQ-025 read_chunk falling before ack (protocol violation): a started TLP still completes; ack is still issued.
REQ-026 tbuf_av[1] is sampled only in IDLE; losing it mid-packet has no effect.

Reset
REQ-027 Reset values: tsrc_rdy_n=1, tsof_n=1, teof_n=1, tsrc_dsc_n=1, td=0, trem_n=0, read_chunk_ack=0, tag=0, rd_req_count=0, FSM=IDLE.
REQ-028 Reset mid-packet aborts at once with outputs at reset values; no partial TLP resumes after reset.

Configuration
REQ-029 Macro MRD32_OPT_EN.
- Defined: when addr[63:32]==0, emit a 3DW MRd32 instead: fmt/type=7'b00_00000.
- MRd32 BEAT1: td={addr[31:2], 2'b00, 32'h0}, trem_n=8'h0F.
- Undefined: always MRd64.

Structure
REQ-030 Shared package/includes holds:
- fmt/type constants MRD64_FMT_TYPE and MRD32_FMT_TYPE
- CHUNK_LEN_DW=128
- FSM state constants
REQ-031 One sub-module, rd_req_hdr_build: combinational header DW0..DW3 from address, tag and id; the FSM instantiates it.

Verification
REQ-032 Basic request: addr=64'h0000_0001_2345_6000, id=16'h0100, tdst_rdy_n=0.
- Beat0 = 64'h2000_0080_0100_00FF.
- Beat1 = 64'h0000_0001_2345_6000.
- Ack one cycle after beat1; tag -> 1.
REQ-033 Backpressure: tdst_rdy_n=1 for 5 cycles during BEAT0, then again during BEAT1.
- Beats held stable throughout.
- Exactly one ack.
REQ-034 No credit: trn_tbuf_av[1]=0 for 10 cycles with read_chunk=1.
- tsrc_rdy_n stays 1.
- TLP starts the cycle after the bit rises.
REQ-035 Wrap: 256 back-to-back requests.
- Tags 0..255 then 0.
- rd_req_count=256.
- Minimum 4 cycles per request.
REQ-036 Reset during BEAT1: all outputs at reset values next cycle; no ack.
REQ-037 With MRD32_OPT_EN, addr=64'h0000_0000_8000_0200.
- Beat0 = 64'h0000_0080_0100_00FF.
- Beat1 = 64'h8000_0200_0000_0000, trem_n=8'h0F.
